// File: rtl/iddr_pkg.sv
// Shared types and helpers for the DDR receive deserialiser.
// Holds the FSM encoding and the slot/keep arithmetic used by the packer.
package iddr_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Width of a field that counts 0..2*ratio half-words.
  function automatic int keep_w(input int ratio);
    return $clog2(2 * ratio + 1);
  endfunction

  function automatic int slots_per_word(input int ratio);
    return 2 * ratio;
  endfunction

  // LSB position of half-word slot within a packed word.
  function automatic int hw_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/iddr_capture.sv
// DDR capture stage: one rising and one falling flop per lane, both
// re-registered on the rising edge into an aligned {rise, fall} beat.
module iddr_capture #(
  parameter int LANES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] din,
  output logic [LANES-1:0] rise,
  output logic [LANES-1:0] fall,
  output logic             beat_ok
);

  logic [LANES-1:0] pos_r;
  logic [LANES-1:0] neg_r;
  logic             pos_ok_r;

  // Rising-edge sample; pos_ok_r marks that the sample postdates reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_r    <= '0;
      pos_ok_r <= 1'b0;
    end else begin
      pos_r    <= din;
      pos_ok_r <= 1'b1;
    end
  end

  // Falling-edge sample, deliberately left without reset.
  always_ff @(negedge clk) begin
    neg_r <= din;
  end

  // Realign both samples onto the rising edge as one beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise    <= '0;
      fall    <= '0;
      beat_ok <= 1'b0;
    end else begin
      rise    <= pos_r;
      fall    <= neg_r;
      beat_ok <= pos_ok_r;
    end
  end

endmodule

// File: rtl/iddr_deser.sv
// RGMII-style DDR receive deserialiser: captures data + control lanes on
// both edges, decodes valid/error and packs beats into framed words.
module iddr_deser
  import iddr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RATIO = 2,
  parameter int SWAP  = 0,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            d,
  input  logic                        ctl,
  input  logic                        ddr_en,
  output logic [2*WIDTH*RATIO-1:0]    q_data,
  output logic [keep_w(RATIO)-1:0]    q_keep,
  output logic                        q_valid,
  output logic                        q_last,
  output logic                        q_err,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic [CNT_W-1:0]            err_cnt
);

  localparam int OUT_W = 2 * WIDTH * RATIO;
  localparam int SLOTS = slots_per_word(RATIO);
  localparam int KW    = keep_w(RATIO);

  logic [WIDTH:0]   rise_s;
  logic [WIDTH:0]   fall_s;
  logic             beat_ok_s;

  state_t           state_r, state_n;
  logic             mode_r, mode_n;
  logic             frame_err_r, frame_err_n;
  logic [OUT_W-1:0] acc_data_r, acc_data_n;
  logic [KW-1:0]    acc_slots_r, acc_slots_n;
  logic             acc_err_r, acc_err_n;
  logic             pend_valid_r, pend_valid_n;
  logic [OUT_W-1:0] pend_data_r, pend_data_n;
  logic             pend_err_r, pend_err_n;

  logic             beat_dv_s, beat_ddr_s, beat_err_s;
  logic [WIDTH-1:0] hw0_s, hw1_s;
  logic [KW-1:0]    hw_cnt_s, base_slots_s, new_slots_s;
  logic [OUT_W-1:0] base_data_s, packed_data_s;
  logic             base_err_s, packed_err_s, packed_full_s;
  logic [OUT_W-1:0] pk_acc_data_s;
  logic [KW-1:0]    pk_acc_slots_s;
  logic             pk_acc_err_s, pk_pend_s;

  logic             emit_s, emit_last_s, emit_err_s;
  logic [OUT_W-1:0] emit_data_s;
  logic [KW-1:0]    emit_keep_s;

  iddr_capture #(.LANES(WIDTH + 1)) u_capture (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     ({ctl, d}),
    .rise    (rise_s),
    .fall    (fall_s),
    .beat_ok (beat_ok_s)
  );

  // Beat decode; the mode is the latched one inside a frame, live otherwise.
  always_comb begin
    beat_dv_s = beat_ok_s & rise_s[WIDTH];
    if (state_r == ST_ACTIVE) begin
      beat_ddr_s = mode_r;
    end else begin
      beat_ddr_s = ddr_en;
    end
    beat_err_s = beat_ddr_s & (rise_s[WIDTH] ^ fall_s[WIDTH]);
    if (beat_ddr_s) begin
      hw_cnt_s = KW'(2);
      if (SWAP != 0) begin
        hw0_s = fall_s[WIDTH-1:0];
        hw1_s = rise_s[WIDTH-1:0];
      end else begin
        hw0_s = rise_s[WIDTH-1:0];
        hw1_s = fall_s[WIDTH-1:0];
      end
    end else begin
      hw_cnt_s = KW'(1);
      hw0_s    = rise_s[WIDTH-1:0];
      hw1_s    = '0;
    end
  end

  // Place the beat's half-words at the current slot; a frame start packs at slot 0.
  always_comb begin
    if (state_r == ST_ACTIVE) begin
      base_slots_s = acc_slots_r;
      base_data_s  = acc_data_r;
      base_err_s   = acc_err_r;
    end else begin
      base_slots_s = '0;
      base_data_s  = '0;
      base_err_s   = 1'b0;
    end
    packed_data_s = base_data_s;
    for (int i = 0; i < SLOTS; i++) begin
      if (base_slots_s == KW'(i)) begin
        packed_data_s[hw_lsb(i, WIDTH) +: WIDTH] = hw0_s;
      end else if ((hw_cnt_s == KW'(2)) && ((base_slots_s + KW'(1)) == KW'(i))) begin
        packed_data_s[hw_lsb(i, WIDTH) +: WIDTH] = hw1_s;
      end else begin
        packed_data_s[hw_lsb(i, WIDTH) +: WIDTH] = base_data_s[hw_lsb(i, WIDTH) +: WIDTH];
      end
    end
    new_slots_s   = base_slots_s + hw_cnt_s;
    packed_full_s = (new_slots_s == KW'(SLOTS));
    packed_err_s  = base_err_s | beat_err_s;
  end

  // A filled word moves to pending and leaves an empty accumulator behind.
  always_comb begin
    if (packed_full_s) begin
      pk_acc_data_s  = '0;
      pk_acc_slots_s = '0;
      pk_acc_err_s   = 1'b0;
      pk_pend_s      = 1'b1;
    end else begin
      pk_acc_data_s  = packed_data_s;
      pk_acc_slots_s = new_slots_s;
      pk_acc_err_s   = packed_err_s;
      pk_pend_s      = 1'b0;
    end
  end

  // Frame FSM next state and word emission.
  always_comb begin
    state_n      = state_r;
    mode_n       = mode_r;
    frame_err_n  = frame_err_r;
    acc_data_n   = acc_data_r;
    acc_slots_n  = acc_slots_r;
    acc_err_n    = acc_err_r;
    pend_valid_n = pend_valid_r;
    pend_data_n  = pend_data_r;
    pend_err_n   = pend_err_r;
    emit_s       = 1'b0;
    emit_last_s  = 1'b0;
    emit_err_s   = 1'b0;
    emit_data_s  = '0;
    emit_keep_s  = '0;
    case (state_r)
      ST_RESYNC: begin
        if (beat_ok_s && !beat_dv_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RESYNC;
        end
      end
      ST_IDLE: begin
        if (beat_dv_s) begin
          state_n      = ST_ACTIVE;
          mode_n       = ddr_en;
          frame_err_n  = beat_err_s;
          acc_data_n   = pk_acc_data_s;
          acc_slots_n  = pk_acc_slots_s;
          acc_err_n    = pk_acc_err_s;
          pend_valid_n = pk_pend_s;
          pend_data_n  = packed_data_s;
          pend_err_n   = packed_err_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (beat_dv_s) begin
          frame_err_n = frame_err_r | beat_err_s;
          if (pend_valid_r) begin
            emit_s      = 1'b1;
            emit_data_s = pend_data_r;
            emit_keep_s = KW'(SLOTS);
            emit_err_s  = pend_err_r;
          end else begin
            emit_s = 1'b0;
          end
          acc_data_n   = pk_acc_data_s;
          acc_slots_n  = pk_acc_slots_s;
          acc_err_n    = pk_acc_err_s;
          pend_valid_n = pk_pend_s;
          pend_data_n  = packed_data_s;
          pend_err_n   = packed_err_s;
        end else begin
          state_n = ST_IDLE;
          if (pend_valid_r) begin
            emit_s      = 1'b1;
            emit_last_s = 1'b1;
            emit_data_s = pend_data_r;
            emit_keep_s = KW'(SLOTS);
            emit_err_s  = pend_err_r;
          end else if (acc_slots_r != '0) begin
            emit_s      = 1'b1;
            emit_last_s = 1'b1;
            emit_data_s = acc_data_r;
            emit_keep_s = acc_slots_r;
            emit_err_s  = acc_err_r;
          end else begin
            emit_s = 1'b0;
          end
          acc_data_n   = '0;
          acc_slots_n  = '0;
          acc_err_n    = 1'b0;
          pend_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_RESYNC;
      end
    endcase
  end

  // FSM, accumulator and pending-word registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_RESYNC;
      mode_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      acc_data_r   <= '0;
      acc_slots_r  <= '0;
      acc_err_r    <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_data_r  <= '0;
      pend_err_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      mode_r       <= mode_n;
      frame_err_r  <= frame_err_n;
      acc_data_r   <= acc_data_n;
      acc_slots_r  <= acc_slots_n;
      acc_err_r    <= acc_err_n;
      pend_valid_r <= pend_valid_n;
      pend_data_r  <= pend_data_n;
      pend_err_r   <= pend_err_n;
    end
  end

  // Registered word output; q_data/q_keep hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_data  <= '0;
      q_keep  <= '0;
      q_valid <= 1'b0;
      q_last  <= 1'b0;
      q_err   <= 1'b0;
    end else if (emit_s) begin
      q_data  <= emit_data_s;
      q_keep  <= emit_keep_s;
      q_valid <= 1'b1;
      q_last  <= emit_last_s;
      q_err   <= emit_err_s;
    end else begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
      q_err   <= 1'b0;
    end
  end

  // Saturating per-frame statistics, stepped by the frame's final word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (emit_s && emit_last_s) begin
      if (frame_cnt != '1) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else begin
        frame_cnt <= frame_cnt;
      end
      if (frame_err_r && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end else begin
        err_cnt <= err_cnt;
      end
    end else begin
      frame_cnt <= frame_cnt;
      err_cnt   <= err_cnt;
    end
  end

endmodule

// File: tb/tb_iddr_deser.sv
// Self-checking bench for iddr_deser: a SWAP=0 instance and a SWAP=1 instance
// with 2-bit counters share stimulus and are checked against a frame-level model.
module tb_iddr_deser;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  keep;
    logic        last;
    logic        err;
    int          edge_n;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  d = 4'h0;
  logic        ctl = 1'b0;
  logic        ddr_en = 1'b1;
  logic [15:0] q_data_a, q_data_b;
  logic [2:0]  q_keep_a, q_keep_b;
  logic        q_valid_a, q_valid_b, q_last_a, q_last_b, q_err_a, q_err_b;
  logic [15:0] frame_cnt_a, err_cnt_a;
  logic [1:0]  frame_cnt_b, err_cnt_b;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  word_t       expa[$], expb[$], obsa[$], obsb[$], wq[$];
  logic [3:0]  fr_r[16], fr_f[16];
  logic        fr_cf[16];
  int          fr_e[16];
  int          fa = 0, ea = 0, fb = 0, eb = 0;
  logic        ferr;

  iddr_deser #(.WIDTH(4), .RATIO(2), .SWAP(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d), .ctl(ctl), .ddr_en(ddr_en),
    .q_data(q_data_a), .q_keep(q_keep_a), .q_valid(q_valid_a), .q_last(q_last_a),
    .q_err(q_err_a), .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a)
  );

  iddr_deser #(.WIDTH(4), .RATIO(2), .SWAP(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d), .ctl(ctl), .ddr_en(ddr_en),
    .q_data(q_data_b), .q_keep(q_keep_b), .q_valid(q_valid_b), .q_last(q_last_b),
    .q_err(q_err_b), .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the rising-edge number that produced it.
  always @(negedge clk) begin
    if (q_valid_a) obsa.push_back('{q_data_a, q_keep_a, q_last_a, q_err_a, cyc});
    if (q_valid_b) obsb.push_back('{q_data_b, q_keep_b, q_last_b, q_err_b, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat: rise value before the rising edge, fall value before the falling edge.
  task automatic beat(input logic [3:0] r, input logic [3:0] f, input logic cr,
                      input logic cf, output int e);
    d = r; ctl = cr;
    @(posedge clk); #2;
    e = cyc;
    d = f; ctl = cf;
    @(negedge clk); #2;
  endtask

  task automatic idle_beats(input int n);
    int e;
    for (int i = 0; i < n; i++) beat(4'($urandom), 4'($urandom), 1'b0, 1'($urandom), e);
  endtask

  // Reference: flatten the frame into half-words and cut them into 4-slot words.
  task automatic build(input bit swap, input bit mode, input int n);
    logic [3:0] hw[$];
    int         hb[$];
    logic       he[$];
    word_t      w;
    int         slot;
    logic       e;
    hw.delete(); hb.delete(); he.delete(); wq.delete();
    ferr = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = mode & ~fr_cf[i];
      ferr = ferr | e;
      if (!mode) begin
        hw.push_back(fr_r[i]); hb.push_back(i); he.push_back(1'b0);
      end else if (swap) begin
        hw.push_back(fr_f[i]); hw.push_back(fr_r[i]);
        hb.push_back(i); hb.push_back(i); he.push_back(e); he.push_back(e);
      end else begin
        hw.push_back(fr_r[i]); hw.push_back(fr_f[i]);
        hb.push_back(i); hb.push_back(i); he.push_back(e); he.push_back(e);
      end
    end
    w = '{16'h0, 3'd0, 1'b0, 1'b0, 0};
    slot = 0;
    for (int h = 0; h < hw.size(); h++) begin
      w.data[slot*4 +: 4] = hw[h];
      w.err = w.err | he[h];
      w.edge_n = fr_e[hb[h]] + 3;
      slot++;
      if (slot == 4 || h == hw.size() - 1) begin
        w.keep = 3'(slot);
        w.last = (h == hw.size() - 1);
        wq.push_back(w);
        w = '{16'h0, 3'd0, 1'b0, 1'b0, 0};
        slot = 0;
      end
    end
  endtask

  task automatic send_frame(input bit mode, input int n, input int gap, input bit flip);
    int e;
    ddr_en = mode;
    for (int i = 0; i < n; i++) begin
      beat(fr_r[i], fr_f[i], 1'b1, fr_cf[i], e);
      fr_e[i] = e;
      if (flip && i == 2) ddr_en = ~mode;
    end
    idle_beats(gap);
    build(1'b0, mode, n);
    foreach (wq[k]) expa.push_back(wq[k]);
    fa++; if (ferr) ea++;
    build(1'b1, mode, n);
    foreach (wq[k]) expb.push_back(wq[k]);
    if (fb < 3) fb++;
    if (ferr && eb < 3) eb++;
  endtask

  task automatic check_group(input string tag);
    int n;
    idle_beats(4);
    chk({tag, "_cnt_a"}, obsa.size(), expa.size());
    chk({tag, "_cnt_b"}, obsb.size(), expb.size());
    n = (obsa.size() < expa.size()) ? obsa.size() : expa.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_a_data"}, obsa[i].data, expa[i].data);
      chk({tag, "_a_keep"}, obsa[i].keep, expa[i].keep);
      chk({tag, "_a_last"}, obsa[i].last, expa[i].last);
      chk({tag, "_a_err"},  obsa[i].err,  expa[i].err);
      chk({tag, "_a_edge"}, obsa[i].edge_n, expa[i].edge_n);
    end
    n = (obsb.size() < expb.size()) ? obsb.size() : expb.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_b_data"}, obsb[i].data, expb[i].data);
      chk({tag, "_b_keep"}, obsb[i].keep, expb[i].keep);
      chk({tag, "_b_last"}, obsb[i].last, expb[i].last);
      chk({tag, "_b_err"},  obsb[i].err,  expb[i].err);
      chk({tag, "_b_edge"}, obsb[i].edge_n, expb[i].edge_n);
    end
    chk({tag, "_frame_cnt_a"}, frame_cnt_a, fa);
    chk({tag, "_err_cnt_a"},   err_cnt_a,   ea);
    chk({tag, "_frame_cnt_b"}, frame_cnt_b, fb);
    chk({tag, "_err_cnt_b"},   err_cnt_b,   eb);
    obsa.delete(); obsb.delete(); expa.delete(); expb.delete();
  endtask

  task automatic load_count(input int n);
    for (int i = 0; i < n; i++) begin
      fr_r[i] = 4'(2*i + 1); fr_f[i] = 4'(2*i + 2); fr_cf[i] = 1'b1;
    end
  endtask

  initial begin
    int e;
    int n;
    bit m;
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", q_valid_a, 1'b0);
    chk("rst_data",  q_data_a,  16'h0);
    chk("rst_keep",  q_keep_a,  3'd0);
    chk("rst_last",  q_last_a,  1'b0);
    chk("rst_err",   q_err_a,   1'b0);
    chk("rst_fcnt",  frame_cnt_a, 16'd0);
    chk("rst_ecnt",  err_cnt_a,   16'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    idle_beats(3);

    // Full two-word DDR frame
    load_count(4);
    send_frame(1'b1, 4, 2, 1'b0);
    idle_beats(4);
    chk("t1_w0_data", obsa[0].data, 16'h4321);
    chk("t1_w0_last", obsa[0].last, 1'b0);
    chk("t1_w1_data", obsa[1].data, 16'h8765);
    chk("t1_w1_keep", obsa[1].keep, 3'd4);
    chk("t1_w1_last", obsa[1].last, 1'b1);
    chk("t1_swap_w0", obsb[0].data, 16'h3412);
    check_group("full");

    // Partial final word
    load_count(3);
    send_frame(1'b1, 3, 2, 1'b0);
    check_group("partial");

    // Error on the second beat only
    load_count(4);
    fr_cf[1] = 1'b0;
    send_frame(1'b1, 4, 2, 1'b0);
    check_group("error");

    // SDR, rising nibbles A..E
    for (int i = 0; i < 5; i++) begin
      fr_r[i] = 4'(10 + i); fr_f[i] = 4'(i); fr_cf[i] = 1'($urandom);
    end
    send_frame(1'b0, 5, 2, 1'b0);
    check_group("sdr");

    // Back-to-back frames separated by a single idle beat
    load_count(2);
    send_frame(1'b1, 2, 1, 1'b0);
    load_count(3);
    send_frame(1'b1, 3, 1, 1'b0);
    check_group("b2b");

    // Randomised frames with mixed modes and mid-frame ddr_en changes
    for (int g = 0; g < 6; g++) begin
      for (int f = 0; f < 5; f++) begin
        m = 1'($urandom);
        n = $urandom_range(2, 9);
        for (int i = 0; i < n; i++) begin
          fr_r[i] = 4'($urandom); fr_f[i] = 4'($urandom);
          fr_cf[i] = ($urandom_range(0, 7) != 0);
        end
        send_frame(m, n, $urandom_range(1, 3), (n >= 4));
      end
      check_group("rand");
    end

    // Reset mid-frame, released while ctl is still high
    ddr_en = 1'b1;
    for (int i = 0; i < 3; i++) beat(4'(i), 4'(i + 8), 1'b1, 1'b1, e);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) beat(4'(i), 4'(i + 4), 1'b1, 1'b1, e);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) beat(4'($urandom), 4'($urandom), 1'b1, 1'b1, e);
    fa = 0; ea = 0; fb = 0; eb = 0;
    chk("resync_quiet_a", obsa.size(), 0);
    chk("resync_quiet_b", obsb.size(), 0);
    chk("resync_fcnt_a", frame_cnt_a, 16'd0);
    chk("resync_ecnt_a", err_cnt_a, 16'd0);
    chk("resync_fcnt_b", frame_cnt_b, 2'd0);
    obsa.delete(); obsb.delete(); expa.delete(); expb.delete();
    idle_beats(1);
    load_count(2);
    send_frame(1'b1, 2, 2, 1'b0);
    idle_beats(4);
    chk("resync_word", obsa[0].data, 16'h4321);
    chk("resync_last", obsa[0].last, 1'b1);
    chk("resync_swap", obsb[0].data, 16'h3412);
    check_group("resync");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iddr_deser.md
# iddr_deser

Parametrised DDR receive deserialiser for the RGMII-style receive path. It captures WIDTH data lanes plus one control lane on both clock edges, decodes per-beat valid and error from the control lane, and packs beats into OUT_W-bit words with frame framing (last, keep). It sits directly behind the pads, ahead of the MAC receive logic. It supports runtime DDR/SDR selection, edge-order swap, and per-frame statistics.

## Interface
- WIDTH, 4: data lanes per edge; one half-word = WIDTH bits.
- RATIO, 2: beats (clock cycles of DDR data) per output word; OUT_W = 2*WIDTH*RATIO.
- SWAP, 0: 1 = falling-edge sample occupies the lower half of each beat.
- CNT_W, 16: statistics counter width.
- clk  in  1  sole clock; data sampled on both edges.
- rst_n  in  1  synchronous, active-low reset.
- d  in  WIDTH  DDR data lanes.
- ctl  in  1  DDR control lane (valid on rise, valid^error on fall).
- ddr_en  in  1  1 = DDR, 0 = SDR (rising samples only); latched at frame start.
- q_data  out  OUT_W  packed word; first half-word in bits [WIDTH-1:0].
- q_keep  out  $clog2(2*RATIO+1)  number of valid half-words in q_data.
- q_valid  out  1  one-cycle word strobe; no backpressure.
- q_last  out  1  word is final word of frame.
- q_err  out  1  OR of beat errors packed into this word.
- frame_cnt  out  CNT_W  frames completed, saturating.
- err_cnt  out  CNT_W  frames with any error, saturating.

## Operation
- Capture: per lane, posedge flop and negedge flop, re-registered on posedge into aligned beat {rise, fall}. Negedge flops are not reset. All posedge flops reset.
- Beat decode: dv = ctl_rise; err = ctl_rise ^ ctl_fall in DDR, 0 in SDR.
- Half-words per beat:
  - DDR: 2, in order rise,fall, or fall,rise when SWAP=1.
  - SDR: 1, the rise sample.
- Accumulator holds slot count 0..2*RATIO. Unused bits are driven to 0.
- FSM:
  - RESYNC (reset state): wait for a dv=0 beat, then go to IDLE. Frames already in progress at reset release are discarded.
  - IDLE: dv=1 → latch ddr_en, pack beat at slot 0, go to ACTIVE.
  - ACTIVE, dv=1: pack beat. When the word fills, move it to the pending register and clear slots.
  - ACTIVE, dv=0: go to IDLE and emit the final word:
    - pending full word, or
    - partial accumulator (slots>0), keep=slots.
  - In both cases q_last=1.
- Pending word with the next beat dv=1: emit it with q_last=0, keep=2*RATIO. The new beat packs in the same cycle.
- At most one emission per cycle. A pending word and a partial accumulator never coexist.
- q_err covers the beats inside the emitted word only.
- On any emission with q_last=1:
  - frame_cnt increments.
  - err_cnt increments if any beat of the frame had err.
  - Both counters saturate at all-ones.
- ddr_en changes during ACTIVE take effect at the next frame start.
- One dv=0 beat between frames is sufficient; the back-to-back frame starts on the next beat.

## Timing
- Reset values: q_data=0, q_keep=0, q_valid=0, q_last=0, q_err=0, frame_cnt=0, err_cnt=0. The FSM enters RESYNC.
- Reset asserted mid-frame drops the accumulator and pending word; no further q_valid.
- Beat sampled at rising edge k is in capture regs after edge k+1 and in the FSM/accumulator after edge k+2.
- Latency: q_valid asserts after edge j+3, where j is the rising edge sampling the word's final beat. This holds for both full and partial words.
- q_valid is a single-cycle pulse. Minimum spacing is RATIO cycles in DDR and 2*RATIO cycles in SDR.

## Structure
- Package iddr_pkg:
  - FSM state enum (RESYNC, IDLE, ACTIVE).
  - keep-width function.
  - Half-word index helpers.
- Sub-module iddr_capture: WIDTH+1-lane DDR capture stage producing the aligned {rise, fall} beat, parametrised by lane count.

## Test plan
- DDR, WIDTH=4, RATIO=2; 4 beats rise/fall 1/2, 3/4, 5/6, 7/8; ctl 1/1; then ctl 0.
  - Expect q_data=16'h4321 (last=0).
  - Then 16'h8765 with keep=4, last=1, err=0; frame_cnt=1.
- Partial: 3 beats 1/2, 3/4, 5/6, then ctl 0.
  - Expect 16'h4321 (last=0).
  - Then 16'h0065 with keep=2, last=1.
- Error: beat 2 with ctl rise=1, fall=0.
  - Expect the first word with q_err=1, the second with q_err=0; err_cnt=1.
- SDR (ddr_en=0): rise nibbles A, B, C, D, E.
  - Expect 16'hDCBA with keep=4, last=0.
  - Then 16'h000E with keep=1, last=1.
- Reset held 3 cycles mid-frame, released with ctl still high.
  - Expect no q_valid until ctl drops for one beat.
  - The next frame of 1/2, 3/4 yields 16'h4321 with last=1.
  - Counters read 0 before that frame.
- SWAP=1 instance: beats 1/2, 3/4.
  - Expect 16'h3412 with last=1.
